// File: rtl/sd_data_crc_rx.sv
// SD 1-bit DAT receiver: start-bit detect, MSB-first byte deserialiser, CRC16-CCITT check, end-bit check.
// Optional start-bit timeout in WAIT_START enabled by defining SD_DATA_RX_TIMEOUT_EN.
module sd_data_crc_rx #(
  parameter int BLKSIZE_W    = 10,
  parameter int TIMEOUT_BITS = 1024
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [BLKSIZE_W-1:0] blksize_i,
  input  logic                 bit_en_i,
  input  logic                 dat_i,
  output logic [7:0]           data_o,
  output logic                 data_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 crc_err_o,
  output logic                 end_err_o,
  output logic                 timeout_o
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_CRC, S_END} state_t;

  state_t               state_q, state_d;
  logic [BLKSIZE_W:0]   blk_q, blk_d;
  logic [BLKSIZE_W:0]   byte_cnt_q, byte_cnt_d;
  logic [BLKSIZE_W:0]   byte_nxt;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [3:0]           crc_cnt_q, crc_cnt_d;
  logic [6:0]           shift_q, shift_d;
  logic [15:0]          crc_q, crc_d;
  logic [15:0]          rx_crc_q, rx_crc_d;
  logic [7:0]           data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 done_q, done_d;
  logic                 crc_err_q, crc_err_d;
  logic                 end_err_q, end_err_d;
  logic                 fb;

`ifdef SD_DATA_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_BITS + 1);
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 timeout_q, timeout_d;
`endif

  assign byte_nxt = byte_cnt_q + 1'b1;
  assign fb       = dat_i ^ crc_q[15];

  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    byte_cnt_d   = byte_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    crc_cnt_d    = crc_cnt_q;
    shift_d      = shift_q;
    crc_d        = crc_q;
    rx_crc_d     = rx_crc_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    done_d       = 1'b0;
    crc_err_d    = crc_err_q;
    end_err_d    = end_err_q;
`ifdef SD_DATA_RX_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    timeout_d    = timeout_q;
`endif
    // Abort wins over everything; a partially assembled byte is simply dropped.
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_i) begin
          // Zero length means the full 2^BLKSIZE_W bytes, hence the extra counter bit.
          blk_d      = (blksize_i == '0) ? {1'b1, {BLKSIZE_W{1'b0}}} : {1'b0, blksize_i};
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          crc_cnt_d  = '0;
          shift_d    = '0;
          crc_d      = '0;
          rx_crc_d   = '0;
          crc_err_d  = 1'b0;
          end_err_d  = 1'b0;
`ifdef SD_DATA_RX_TIMEOUT_EN
          to_cnt_d   = '0;
          timeout_d  = 1'b0;
`endif
          state_d    = S_WAIT;
        end
        S_WAIT: if (bit_en_i) begin
          if (!dat_i) begin
            state_d = S_DATA;
          end else begin
`ifdef SD_DATA_RX_TIMEOUT_EN
            if (to_cnt_q == TO_W'(TIMEOUT_BITS - 1)) begin
              done_d    = 1'b1;
              timeout_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
          end
        end
        S_DATA: if (bit_en_i) begin
          shift_d   = {shift_q[5:0], dat_i};
          crc_d     = {crc_q[14:12], crc_q[11] ^ fb, crc_q[10:5], crc_q[4] ^ fb, crc_q[3:0], fb};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            data_d       = {shift_q, dat_i};
            data_valid_d = 1'b1;
            byte_cnt_d   = byte_nxt;
            if (byte_nxt == blk_q) state_d = S_CRC;
          end
        end
        S_CRC: if (bit_en_i) begin
          rx_crc_d  = {rx_crc_q[14:0], dat_i};
          crc_cnt_d = crc_cnt_q + 1'b1;
          if (crc_cnt_q == 4'd15) state_d = S_END;
        end
        S_END: if (bit_en_i) begin
          done_d    = 1'b1;
          crc_err_d = (rx_crc_q != crc_q);
          end_err_d = ~dat_i;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      blk_q        <= '0;
      byte_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      crc_cnt_q    <= '0;
      shift_q      <= '0;
      crc_q        <= '0;
      rx_crc_q     <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      crc_err_q    <= 1'b0;
      end_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      byte_cnt_q   <= byte_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      crc_cnt_q    <= crc_cnt_d;
      shift_q      <= shift_d;
      crc_q        <= crc_d;
      rx_crc_q     <= rx_crc_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
      crc_err_q    <= crc_err_d;
      end_err_q    <= end_err_d;
    end
  end

`ifdef SD_DATA_RX_TIMEOUT_EN
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign crc_err_o    = crc_err_q;
  assign end_err_o    = end_err_q;

endmodule

// File: tb/tb_sd_data_crc_rx.sv
// Randomised bench for sd_data_crc_rx against a polynomial-division CRC model and a byte queue.
module tb_sd_data_crc_rx;
  localparam int BW = 9;
  localparam int TO = 16;

  logic          sd_clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0, abort_i = 1'b0, bit_en_i = 1'b0, dat_i = 1'b1;
  logic [BW-1:0] blksize_i = '0;
  logic [7:0]    data_o;
  logic          data_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o;

  sd_data_crc_rx #(.BLKSIZE_W(BW), .TIMEOUT_BITS(TO)) dut (
    .sd_clk(sd_clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .blksize_i(blksize_i), .bit_en_i(bit_en_i), .dat_i(dat_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .busy_o(busy_o), .done_o(done_o),
    .crc_err_o(crc_err_o), .end_err_o(end_err_o), .timeout_o(timeout_o));

  always #5 sd_clk = ~sd_clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] rx_q[$];
  int done_cnt = 0;
  logic cap_crc, cap_end, cap_to;

  always @(negedge sd_clk) if (!rst) begin
    if (data_valid_o) rx_q.push_back(data_o);
    if (done_o) begin
      done_cnt++;
      cap_crc = crc_err_o; cap_end = end_err_o; cap_to = timeout_o;
    end
  end

  // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] model_crc(input logic [7:0] d[$]);
    int unsigned rem = 0;
    foreach (d[k]) for (int i = 7; i >= 0; i--) begin
      rem = (rem << 1) | 32'(d[k][i]);
      if (rem & 32'h10000) rem ^= 32'h11021;
    end
    for (int i = 0; i < 16; i++) begin
      rem = rem << 1;
      if (rem & 32'h10000) rem ^= 32'h11021;
    end
    return rem[15:0];
  endfunction

  task automatic cyc(input logic en, input logic d);
    @(posedge sd_clk); #1;
    bit_en_i = en; dat_i = d; start_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gapmax, input bit poke);
    int g = $urandom_range(0, gapmax);
    for (int i = 0; i < g; i++) begin
      cyc(1'b0, 1'($urandom));
      if (poke && $urandom_range(0, 40) == 0) begin
        start_i = 1'b1; blksize_i = BW'($urandom);
      end
    end
    cyc(1'b1, b);
  endtask

  task automatic pulse_start(input int nb);
    @(posedge sd_clk); #1;
    start_i = 1'b1; blksize_i = BW'(nb); bit_en_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic run_block(input string nm, input logic [7:0] d[$], input logic [15:0] crc,
                           input logic endb, input int gapmax, input bit poke);
    int d0 = done_cnt;
    int bad = 0;
    logic exp_crc = (model_crc(d) != crc);
    rx_q.delete();
    pulse_start(d.size());
    for (int i = $urandom_range(0, 3); i > 0; i--) send_bit(1'b1, gapmax, poke);
    send_bit(1'b0, gapmax, poke);
    foreach (d[k]) for (int i = 7; i >= 0; i--) send_bit(d[k][i], gapmax, poke);
    for (int i = 15; i >= 0; i--) send_bit(crc[i], gapmax, poke);
    send_bit(endb, gapmax, poke);
    for (int i = 0; i < 8 && done_cnt == d0; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    n_chk++; if (done_cnt - d0 !== 1) begin n_fail++;
      $display("FAIL %s done count: got %0d want 1", nm, done_cnt - d0); end
    n_chk++; if (rx_q.size() !== d.size()) begin n_fail++;
      $display("FAIL %s byte count: got %0d want %0d", nm, rx_q.size(), d.size()); end
    foreach (d[k]) if (k < rx_q.size() && rx_q[k] !== d[k]) bad++;
    n_chk++; if (bad !== 0) begin n_fail++;
      $display("FAIL %s data bytes: %0d wrong, want 0", nm, bad); end
    n_chk++; if (cap_crc !== exp_crc) begin n_fail++;
      $display("FAIL %s crc_err: got %b want %b", nm, cap_crc, exp_crc); end
    n_chk++; if (cap_end !== ~endb) begin n_fail++;
      $display("FAIL %s end_err: got %b want %b", nm, cap_end, ~endb); end
    n_chk++; if (cap_to !== 1'b0) begin n_fail++;
      $display("FAIL %s timeout: got %b want 0", nm, cap_to); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++;
      $display("FAIL %s busy after done: got %b want 0", nm, busy_o); end
  endtask

  task automatic test_reset();
    logic [7:0] d[$];
    repeat (3) @(posedge sd_clk);
    #1;
    n_chk++; if ({data_o, data_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o} !== 14'h0) begin
      n_fail++; $display("FAIL reset outputs: got %h want 0",
        {data_o, data_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o}); end
    rst = 1'b0;
    // Async reset in the middle of a block.
    pulse_start(2);
    send_bit(1'b0, 0, 0);
    for (int i = 0; i < 11; i++) send_bit(1'b1, 0, 0);
    #2 rst = 1'b1; #1;
    n_chk++; if ({data_o, data_valid_o, busy_o, done_o} !== 11'h0) begin n_fail++;
      $display("FAIL async reset mid-block: got %h want 0", {data_o, data_valid_o, busy_o, done_o}); end
    @(posedge sd_clk); #1 rst = 1'b0; bit_en_i = 1'b0;
    d = '{8'hA5, 8'h3C};
    run_block("after_reset", d, model_crc(d), 1'b1, 1, 0);
  endtask

  task automatic test_ff_block(input logic [15:0] crc, input string nm);
    logic [7:0] d[$];
    for (int i = 0; i < 512; i++) d.push_back(8'hFF);
    run_block(nm, d, crc, 1'b1, 1, 0);
  endtask

  task automatic test_zero_block();
    logic [7:0] d[$] = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_block("zero4", d, 16'h0000, 1'b1, 2, 0);
  endtask

  task automatic test_bad_end();
    logic [7:0] d[$];
    for (int i = 0; i < 6; i++) d.push_back(8'($urandom));
    run_block("bad_end", d, model_crc(d), 1'b0, 2, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [7:0] d[$];
      logic [15:0] c;
      int nb = $urandom_range(1, 20);
      for (int i = 0; i < nb; i++) d.push_back(8'($urandom));
      c = model_crc(d);
      if ($urandom_range(0, 2) == 0) c ^= 16'(1 << $urandom_range(0, 15));
      run_block("random", d, c, 1'($urandom_range(0, 3) != 0), 3, 1);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      logic [7:0] d[$];
      for (int i = 0; i < 5; i++) d.push_back(8'($urandom));
      run_block("back_to_back", d, model_crc(d), 1'b1, 0, 0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d[$];
    int d0 = done_cnt;
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
    rx_q.delete();
    pulse_start(8);
    send_bit(1'b0, 1, 0);
    for (int k = 0; k < 3; k++) for (int i = 7; i >= 0; i--) send_bit(d[k][i], 1, 0);
    for (int i = 7; i >= 5; i--) send_bit(d[3][i], 1, 0);
    @(posedge sd_clk); #1;
    abort_i = 1'b1; start_i = 1'b1; bit_en_i = 1'b1; dat_i = d[3][4];
    @(posedge sd_clk); @(negedge sd_clk);
    n_chk++; if (busy_o !== 1'b0) begin n_fail++;
      $display("FAIL abort busy: got %b want 0", busy_o); end
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'($urandom));
    cyc(1'b0, 1'b1);
    n_chk++; if (rx_q.size() !== 3) begin n_fail++;
      $display("FAIL abort byte count: got %0d want 3", rx_q.size()); end
    n_chk++; if (rx_q.size() == 3 && {rx_q[0], rx_q[1], rx_q[2]} !== {d[0], d[1], d[2]}) begin n_fail++;
      $display("FAIL abort bytes: got %h%h%h want %h%h%h", rx_q[0], rx_q[1], rx_q[2], d[0], d[1], d[2]); end
    n_chk++; if (done_cnt !== d0) begin n_fail++;
      $display("FAIL abort done: got %0d pulses want 0", done_cnt - d0); end
    run_block("after_abort", d, model_crc(d), 1'b1, 1, 0);
  endtask

  task automatic test_wait_start();
    int d0 = done_cnt;
    pulse_start(4);
`ifdef SD_DATA_RX_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) send_bit(1'b1, 1, 0);
    repeat (3) cyc(1'b0, 1'b1);
    n_chk++; if (done_cnt !== d0 || busy_o !== 1'b1) begin n_fail++;
      $display("FAIL timeout early: done %0d busy %b want 0 1", done_cnt - d0, busy_o); end
    send_bit(1'b1, 0, 0);
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    n_chk++; if (done_cnt - d0 !== 1) begin n_fail++;
      $display("FAIL timeout done: got %0d want 1", done_cnt - d0); end
    n_chk++; if ({cap_to, cap_crc, cap_end} !== 3'b100) begin n_fail++;
      $display("FAIL timeout flags: got %b want 100", {cap_to, cap_crc, cap_end}); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++;
      $display("FAIL timeout busy: got %b want 0", busy_o); end
`else
    for (int i = 0; i < 10000; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    n_chk++; if (busy_o !== 1'b1 || done_cnt !== d0 || timeout_o !== 1'b0) begin n_fail++;
      $display("FAIL no-timeout wait: busy %b done %0d timeout %b want 1 0 0", busy_o, done_cnt - d0, timeout_o); end
    @(posedge sd_clk); #1 abort_i = 1'b1;
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    n_chk++; if (busy_o !== 1'b0 || done_cnt !== d0) begin n_fail++;
      $display("FAIL no-timeout abort: busy %b done %0d want 0 0", busy_o, done_cnt - d0); end
`endif
  endtask

  initial begin
    test_reset();
    test_ff_block(16'h7FA1, "ff512_good");
    test_zero_block();
    test_ff_block(16'h7FA0, "ff512_badcrc");
    test_wait_start();
    test_bad_end();
    test_random();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
